// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
// Contains the byte S-box and rcon lookup it depends on.

module sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so index by the inverted input.
   logic [7:0] inv_byte;
   assign inv_byte = ~in_byte;
   assign out_byte = SBOX_TBL[{inv_byte, 3'b000} +: 8];
endmodule

module aes_rcon (
   input  logic [3:0]  round_idx,
   output logic [31:0] rcon_out
);
   logic [7:0] rcon_byte;

   always_comb begin
      rcon_byte = 8'h00;
      case (round_idx)
         4'd1:    rcon_byte = 8'h01;
         4'd2:    rcon_byte = 8'h02;
         4'd3:    rcon_byte = 8'h04;
         4'd4:    rcon_byte = 8'h08;
         4'd5:    rcon_byte = 8'h10;
         4'd6:    rcon_byte = 8'h20;
         4'd7:    rcon_byte = 8'h40;
         4'd8:    rcon_byte = 8'h80;
         4'd9:    rcon_byte = 8'h1b;
         4'd10:   rcon_byte = 8'h36;
         default: rcon_byte = 8'h00;
      endcase
   end

   assign rcon_out = {rcon_byte, 24'h000000};
endmodule

module aes_key_expand #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] round_key_out,
   output logic [3:0]   round_num_out,
   output logic         round_key_valid,
   input  logic         round_key_ready,
   output logic         busy,
   output logic         done
);
   localparam int unsigned KW = 128;
   localparam int unsigned CW = 4;

   typedef enum logic {IDLE, EMIT} state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   key_q, key_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [CW-1:0]   rcon_idx;
   logic [31:0]     rcon_word;
   logic [31:0]     w0, w1, w2, w3;
   logic [31:0]     rot_w3, sub_w3, temp;
   logic [KW-1:0]   next_key;
   logic            last_round;

   assign last_round = (cnt_q >= CW'(NR));
   // Clamped so the lookup index stays within 1..NR even on the final round.
   assign rcon_idx = last_round ? CW'(NR) : cnt_q + CW'(1);

   aes_rcon u_rcon (
      .round_idx (rcon_idx),
      .rcon_out  (rcon_word)
   );

   assign {w0, w1, w2, w3} = key_q;
   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      sbox u_sbox (
         .in_byte  (rot_w3[8*b +: 8]),
         .out_byte (sub_w3[8*b +: 8])
      );
   end

   always_comb begin
      logic [31:0] n0, n1, n2, n3;
      temp     = sub_w3 ^ rcon_word;
      n0       = w0 ^ temp;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // Next-state and next-output logic; starts are refused while the done pulse is out.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               key_d   = key_in;
               cnt_d   = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (valid_q && round_key_ready) begin
               if (!last_round) begin
                  key_d = next_key;
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign round_key_out   = key_q;
   assign round_num_out   = cnt_q;
   assign round_key_valid = valid_q;
   assign busy            = busy_q;
   assign done            = done_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: scoreboarded round keys, handshake timing and reset behaviour.

module tb_aes_key_expand;
   logic         clk = 1'b0;
   logic         clk_en = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] round_key_out;
   logic [3:0]   round_num_out;
   logic         round_key_valid;
   logic         round_key_ready;
   logic         busy;
   logic         done;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0]   num;
      logic [127:0] key;
      logic         chk;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

   logic [127:0] k1_tbl [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   aes_key_expand dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .key_in          (key_in),
      .round_key_out   (round_key_out),
      .round_num_out   (round_num_out),
      .round_key_valid (round_key_valid),
      .round_key_ready (round_key_ready),
      .busy            (busy),
      .done            (done)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_k1();
      for (int r = 0; r < 11; r++) exp_q.push_back('{num: 4'(r), key: k1_tbl[r], chk: 1'b1});
   endtask

   task automatic push_k2();
      for (int r = 0; r < 11; r++) exp_q.push_back('{num: 4'(r), key: 128'h0, chk: 1'b0});
      exp_q[exp_q.size()-11].key = K2;
      exp_q[exp_q.size()-11].chk = 1'b1;
      exp_q[exp_q.size()-10].key = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      exp_q[exp_q.size()-10].chk = 1'b1;
      exp_q[exp_q.size()-1].key  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      exp_q[exp_q.size()-1].chk  = 1'b1;
   endtask

   // Called with start already driven for the coming edge; returns at the done
   // negedge, or at the abort round's negedge when abort_round >= 0.
   task automatic run_exp(input int ready_mode, input int inject_round,
                          input int abort_round, output bit aborted);
      int           cyc = 0;
      int           first = -1;
      int           last = -1;
      int           nxfer = 0;
      bit           got_done = 1'b0;
      bit           hold = 1'b0;
      bit           injected = 1'b0;
      logic [127:0] pk = '0;
      logic [3:0]   pn = '0;
      exp_t         e;
      aborted = 1'b0;
      while (!got_done && !aborted && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start  = 1'b0;
         key_in = {$urandom, $urandom, $urandom, $urandom};
         if (cyc == 1) begin
            chk("latency_valid", 128'(round_key_valid), 128'h1);
            chk("busy_running", 128'(busy), 128'h1);
         end
         if (done) begin
            got_done = 1'b1;
            chk("busy_with_done", 128'(busy), 128'h0);
            chk("valid_with_done", 128'(round_key_valid), 128'h0);
            chk("xfer_count", 128'(nxfer), 128'd11);
            if (ready_mode == 0) begin
               chk("xfer_span", 128'(last - first), 128'd10);
               chk("done_timing", 128'(cyc), 128'(last + 1));
            end
         end else if (round_key_valid) begin
            if (hold) begin
               chk("hold_key", round_key_out, pk);
               chk("hold_num", 128'(round_num_out), 128'(pn));
            end
            if (abort_round >= 0 && int'(round_num_out) == abort_round) begin
               aborted = 1'b1;
            end else begin
               if (inject_round >= 0 && int'(round_num_out) == inject_round && !injected) begin
                  injected = 1'b1;
                  start    = 1'b1;
                  key_in   = '0;
               end
               round_key_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
               if (round_key_ready) begin
                  hold = 1'b0;
                  nxfer++;
                  if (first < 0) first = cyc;
                  last = cyc;
                  if (exp_q.size() == 0) begin
                     chk("sb_underflow", 128'(exp_q.size()), 128'd1);
                  end else begin
                     e = exp_q.pop_front();
                     chk("round_num", 128'(round_num_out), 128'(e.num));
                     if (e.chk) chk($sformatf("round_key_%0d", e.num), round_key_out, e.key);
                  end
               end else begin
                  hold = 1'b1;
                  pk   = round_key_out;
                  pn   = round_num_out;
               end
            end
         end else begin
            chk("valid_while_busy", 128'(round_key_valid), 128'h1);
         end
      end
      if (!got_done && !aborted) chk("timeout_done", 128'(got_done), 128'h1);
   endtask

   initial begin
      bit ab;
      rst_n           = 1'b0;
      start           = 1'b0;
      key_in          = '0;
      round_key_ready = 1'b0;

      // Reset values with no clock running
      #5;
      chk("rst_key", round_key_out, 128'h0);
      chk("rst_num", 128'(round_num_out), 128'h0);
      chk("rst_valid", 128'(round_key_valid), 128'h0);
      chk("rst_busy", 128'(busy), 128'h0);
      chk("rst_done", 128'(done), 128'h0);

      clk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // FIPS-197 key, ready held high
      start = 1'b1; key_in = K1; push_k1();
      run_exp(0, -1, -1, ab);
      @(negedge clk);
      chk("post_done_pulse", 128'(done), 128'h0);
      chk("ready_idle_valid", 128'(round_key_valid), 128'h0);
      round_key_ready = 1'b0;

      // Backpressure
      @(negedge clk);
      start = 1'b1; key_in = K1; push_k1();
      run_exp(1, -1, -1, ab);

      // Start while busy during round 4
      @(negedge clk);
      start = 1'b1; key_in = K1; push_k1();
      run_exp(0, 4, -1, ab);

      // Reset mid-operation at round 6
      @(negedge clk);
      start = 1'b1; key_in = K1; push_k1();
      run_exp(0, -1, 6, ab);
      chk("abort_reached", 128'(ab), 128'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_key", round_key_out, 128'h0);
      chk("arst_num", 128'(round_num_out), 128'h0);
      chk("arst_valid", 128'(round_key_valid), 128'h0);
      chk("arst_busy", 128'(busy), 128'h0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_no_done", 128'(done), 128'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_no_done", 128'(done), 128'h0);

      // Fresh key after reset, then back-to-back start on the done cycle
      start = 1'b1; key_in = K2; push_k2();
      run_exp(0, -1, -1, ab);
      start = 1'b1; key_in = K1;
      @(negedge clk);
      chk("b2b_ignored_valid", 128'(round_key_valid), 128'h0);
      chk("b2b_ignored_busy", 128'(busy), 128'h0);
      chk("b2b_done_once", 128'(done), 128'h0);
      key_in = K1; push_k1();
      run_exp(0, -1, -1, ab);

      @(negedge clk);
      chk("sb_empty", 128'(exp_q.size()), 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-schedule engine.
- Accepts a 128-bit cipher key and emits round keys 0..10 one per accepted transfer, over a valid/ready handshake.
- Sits directly downstream of the rcon lookup: it drives the lookup's round index and consumes its 32-bit constant (constant byte in bits [31:24]).
- Feeds the AddRoundKey stage of the round datapath.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128. Any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin expansion; sampled only in IDLE
- key_in  input  128  cipher key, sampled on the accepted start; word w0 = key_in[127:96]
- round_key_out  output  128  current round key, same word order as key_in
- round_num_out  output  4  index of round_key_out, 0..10
- round_key_valid  output  1  round_key_out / round_num_out valid
- round_key_ready  input  1  consumer accepts when valid && ready
- busy  output  1  high from the accepted start until done
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE and all outputs 0 (round_key_out, round_num_out, round_key_valid, busy, done). Internal key register and round counter are also 0.
- States:
  - IDLE: start=1 loads key_in into the key register, sets round counter to 0 and busy=1, and moves to EMIT.
  - EMIT: round_key_valid=1 and outputs are driven from the registers.
    - On valid && ready with counter < 10: key register <= next key, counter += 1, stay in EMIT.
    - On valid && ready with counter == 10: go to IDLE, valid=0, busy=0, done=1 for exactly one cycle.
    - With ready low: all outputs hold stable.
- Latency: start accepted at edge t gives round key 0 valid after edge t. With ready held high, rounds 0..10 appear on 11 consecutive cycles, and done pulses in the 12th cycle.
- Next-key computation is combinational from the key register, with words w0..w3 taken as [127:96]..[31:0]:
  - Rcon lookup index = counter + 1; the block instantiates the rcon lookup internally.
  - temp = SubWord(RotWord(w3)) XOR rcon_out.
  - RotWord(x) = {x[23:0], x[31:24]}.
  - SubWord uses four instances of the team's combinational byte S-box module sbox (8-bit in, 8-bit out).
  - n0 = w0^temp, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- Boundary conditions:
  - start while busy: ignored, and key_in is not re-sampled.
  - start in the same cycle as done: ignored. The first accepted start is one cycle later, in IDLE.
  - Round counter never exceeds 10; the rcon index never exceeds 10.
  - rst_n asserted mid-expansion: immediate abort to IDLE with all outputs 0, and no done pulse.
  - round_key_ready may be high while valid=0; this has no effect.
  - key_in changing after the accepted start: no effect on the running expansion.
- All registers are updated on the rising edge of clk only, apart from the asynchronous reset.

Test Plan:
- FIPS-197 key, ready held high: start with key_in = 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 = same value.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 2 = f2c295f27a96b9435935807a7359f67f.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Transfers on 11 consecutive cycles; done pulses once on the following cycle; busy falls with done.
- Backpressure: same key, ready toggled pseudo-randomly.
  - Round keys and round_num_out are identical to the previous scenario.
  - Outputs are stable whenever valid=1 and ready=0.
  - Exactly 11 transfers and one done pulse.
- Start while busy: assert start with key_in = 0 during round 4.
  - Ignored; round 10 still = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset mid-operation: assert rst_n low during round 6.
  - All outputs go to 0 asynchronously and no done pulse occurs.
  - After release, a new start with key 000102030405060708090a0b0c0d0e0f gives round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: start pulsed on the done cycle is ignored; start on the next cycle is accepted and round 0 appears one cycle later.
- Reset values: with rst_n low and no clock running, all outputs read 0.
